dual_clk_gen: RTL and testbench

Generates two independent, programmable, glitch-free square-wave clocks, p_clk and q_clk, in the sys_clk domain. It drives the period-comparison logic and its benches with known P and Q periods. Each channel's high and low times are set in sys_clk cycles through a valid/ready config port. New settings take effect only at a period boundary.

---
 rtl/dual_clk_gen.sv | 167 ++++++++++++++++
 tb/tb_dual_clk_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_clk_gen.sv
// Two independent programmable square-wave generators in the sys_clk domain.
// High/low times are reconfigured through a valid/ready port and only change on period boundaries.
module dual_clk_gen #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_HIGH = 4,
  parameter int unsigned DEF_LOW  = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en_p,
  input  logic             en_q,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             p_clk,
  output logic             q_clk,
  output logic             p_rise,
  output logic             q_rise
);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  localparam logic [CNT_W-1:0] One     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DefHigh = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DefLow  = CNT_W'(DEF_LOW);

  state_e           state_q    [2];
  state_e           state_d    [2];
  logic [CNT_W-1:0] cnt_q      [2];
  logic [CNT_W-1:0] cnt_d      [2];
  logic [CNT_W-1:0] act_high_q [2];
  logic [CNT_W-1:0] act_high_d [2];
  logic [CNT_W-1:0] act_low_q  [2];
  logic [CNT_W-1:0] act_low_d  [2];
  logic [CNT_W-1:0] sh_high_q  [2];
  logic [CNT_W-1:0] sh_high_d  [2];
  logic [CNT_W-1:0] sh_low_q   [2];
  logic [CNT_W-1:0] sh_low_d   [2];
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       clk_q, clk_d;
  logic [1:0]       rise_q, rise_d;

  logic [1:0]       en;
  logic [1:0]       wr;
  logic [CNT_W-1:0] cfg_high_c;
  logic [CNT_W-1:0] cfg_low_c;

  assign en = {en_q, en_p};

  // Zero-length phases would make the down-counter wrap, so they are coerced to one cycle.
  assign cfg_high_c = (cfg_high == '0) ? One : cfg_high;
  assign cfg_low_c  = (cfg_low == '0) ? One : cfg_low;

  assign cfg_ready = cfg_sel ? ~pend_q[1] : ~pend_q[0];
  assign wr[0]     = cfg_valid & cfg_ready & ~cfg_sel;
  assign wr[1]     = cfg_valid & cfg_ready & cfg_sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      act_high_d[i] = act_high_q[i];
      act_low_d[i]  = act_low_q[i];
      sh_high_d[i]  = sh_high_q[i];
      sh_low_d[i]   = sh_low_q[i];
      pend_d[i]     = pend_q[i];

      unique case (state_q[i])
        StIdle: begin
          // An idle channel takes the write directly so a same-cycle enable uses it.
          if (wr[i]) begin
            act_high_d[i] = cfg_high_c;
            act_low_d[i]  = cfg_low_c;
          end
          if (en[i]) begin
            state_d[i] = StHigh;
            cnt_d[i]   = act_high_d[i] - One;
          end
        end
        StHigh: begin
          if (wr[i]) begin
            sh_high_d[i] = cfg_high_c;
            sh_low_d[i]  = cfg_low_c;
            pend_d[i]    = 1'b1;
          end
          if (cnt_q[i] == '0) begin
            state_d[i] = StLow;
            cnt_d[i]   = act_low_q[i] - One;
          end else begin
            cnt_d[i] = cnt_q[i] - One;
          end
        end
        StLow: begin
          if (wr[i]) begin
            sh_high_d[i] = cfg_high_c;
            sh_low_d[i]  = cfg_low_c;
            pend_d[i]    = 1'b1;
          end
          if (cnt_q[i] == '0) begin
            // Only a write pending before this boundary is applied here.
            if (pend_q[i]) begin
              act_high_d[i] = sh_high_q[i];
              act_low_d[i]  = sh_low_q[i];
              pend_d[i]     = 1'b0;
            end
            if (en[i]) begin
              state_d[i] = StHigh;
              cnt_d[i]   = act_high_d[i] - One;
            end else begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - One;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase

      clk_d[i]  = (state_d[i] == StHigh);
      rise_d[i] = (state_d[i] == StHigh) && (state_q[i] != StHigh);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= StIdle;
        cnt_q[i]      <= '0;
        act_high_q[i] <= DefHigh;
        act_low_q[i]  <= DefLow;
        sh_high_q[i]  <= '0;
        sh_low_q[i]   <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      rise_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        act_high_q[i] <= act_high_d[i];
        act_low_q[i]  <= act_low_d[i];
        sh_high_q[i]  <= sh_high_d[i];
        sh_low_q[i]   <= sh_low_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
    end
  end

  assign p_clk  = clk_q[0];
  assign q_clk  = clk_q[1];
  assign p_rise = rise_q[0];
  assign q_rise = rise_q[1];

endmodule

// File: tb/tb_dual_clk_gen.sv
// Bench for dual_clk_gen: period-position reference model, directed scenarios and random traffic.
module tb_dual_clk_gen;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_p = 1'b0;
  logic       en_q = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       cfg_sel = 1'b0;
  logic [7:0] cfg_high = '0;
  logic [7:0] cfg_low = '0;
  logic       p_clk, q_clk, p_rise, q_rise;

  always #5 sys_clk = ~sys_clk;

  dual_clk_gen #(
    .CNT_W   (8),
    .DEF_HIGH(4),
    .DEF_LOW (4)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .en_p     (en_p),
    .en_q     (en_q),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_high (cfg_high),
    .cfg_low  (cfg_low),
    .p_clk    (p_clk),
    .q_clk    (q_clk),
    .p_rise   (p_rise),
    .q_rise   (q_rise)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // Reference model: each channel is a position inside its current period.
  bit m_run [2];
  int m_pos [2];
  int m_h   [2];
  int m_l   [2];
  int m_sh  [2];
  int m_sl  [2];
  bit m_pend[2];
  bit m_rise[2];

  // Measurements taken from the DUT outputs for the literal checks.
  int last_rise[2];
  int spacing  [2];
  int hi_run   [2];
  int last_hi  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int coerce(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void model_step();
    bit en_v[2];
    en_v[0] = en_p;
    en_v[1] = en_q;
    for (int c = 0; c < 2; c++) begin
      bit acc;
      bit old_pend;
      acc      = cfg_valid && (int'(cfg_sel) == c) && !m_pend[c];
      old_pend = m_pend[c];
      m_rise[c] = 1'b0;
      if (!rst_n) begin
        m_run[c]  = 1'b0;
        m_pos[c]  = 0;
        m_h[c]    = 4;
        m_l[c]    = 4;
        m_sh[c]   = 0;
        m_sl[c]   = 0;
        m_pend[c] = 1'b0;
      end else if (!m_run[c]) begin
        if (acc) begin
          m_h[c] = coerce(int'(cfg_high));
          m_l[c] = coerce(int'(cfg_low));
        end
        if (en_v[c]) begin
          m_run[c]  = 1'b1;
          m_pos[c]  = 0;
          m_rise[c] = 1'b1;
        end
      end else begin
        if (acc) begin
          m_sh[c]   = coerce(int'(cfg_high));
          m_sl[c]   = coerce(int'(cfg_low));
          m_pend[c] = 1'b1;
        end
        m_pos[c]++;
        if (m_pos[c] == m_h[c] + m_l[c]) begin
          if (old_pend) begin
            m_h[c]    = m_sh[c];
            m_l[c]    = m_sl[c];
            m_pend[c] = 1'b0;
          end
          m_pos[c] = 0;
          if (en_v[c]) m_rise[c] = 1'b1;
          else m_run[c] = 1'b0;
        end
      end
    end
  endfunction

  // One clock: check cfg_ready on the applied inputs, advance, then compare all outputs.
  task automatic cyc();
    logic [1:0] r;
    logic [1:0] k;
    #1;
    check("cfg_ready", cfg_ready, !m_pend[cfg_sel]);
    @(posedge sys_clk);
    model_step();
    cyc_n++;
    @(negedge sys_clk);
    check("p_clk", p_clk, m_run[0] && (m_pos[0] < m_h[0]));
    check("q_clk", q_clk, m_run[1] && (m_pos[1] < m_h[1]));
    check("p_rise", p_rise, m_rise[0]);
    check("q_rise", q_rise, m_rise[1]);
    r = {q_rise, p_rise};
    k = {q_clk, p_clk};
    for (int c = 0; c < 2; c++) begin
      if (r[c]) begin
        spacing[c]   = cyc_n - last_rise[c];
        last_rise[c] = cyc_n;
        last_hi[c]   = hi_run[c];
        hi_run[c]    = 1;
      end else if (k[c]) begin
        hi_run[c]++;
      end
    end
  endtask

  task automatic wait_rise(input int ch, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc();
      got = (ch == 0) ? p_rise : q_rise;
    end
    check("wait_rise", got, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (m_run[0] || m_run[1]); i++) cyc();
    check("wait_idle", {m_run[1], m_run[0]}, 2'b00);
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] h, input logic [7:0] l);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_high  = h;
    cfg_low   = l;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int ones;
    int rises;
    logic [31:0] clk_mask;
    logic [31:0] rise_mask;
    int first[2];

    for (int c = 0; c < 2; c++) begin
      m_h[c] = 4;
      m_l[c] = 4;
    end
    @(negedge sys_clk);

    // Reset defaults: 4 high / 4 low, rises at 1, 9, 17.
    repeat (3) cyc();
    rst_n = 1'b1;
    en_p  = 1'b1;
    t0 = cyc_n;
    clk_mask = '0;
    rise_mask = '0;
    ones = 0;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (p_clk) clk_mask[k] = 1'b1;
      if (p_rise) rise_mask[k] = 1'b1;
      if (q_clk) ones++;
    end
    check("reset_clk_pattern", clk_mask, 32'h0002_1E1E);
    check("reset_rise_pattern", rise_mask, 32'h0002_0202);
    check("reset_q_idle", ones, 0);

    // Dual periods, configured while idle, enabled together.
    en_p = 1'b0;
    wait_idle(20);
    cfg_write(1'b0, 8'd3, 8'd2);
    cfg_write(1'b1, 8'd5, 8'd5);
    en_p = 1'b1;
    en_q = 1'b1;
    t0 = cyc_n;
    first[0] = -1;
    first[1] = -1;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (p_rise && first[0] < 0) first[0] = cyc_n - t0;
      if (q_rise && first[1] < 0) first[1] = cyc_n - t0;
    end
    check("dual_first_p", first[0], 1);
    check("dual_first_q", first[1], 1);
    check("dual_spacing_p", spacing[0], 5);
    check("dual_spacing_q", spacing[1], 10);

    // Shadow update mid-HIGH: current period keeps 4/4, next is 2/6.
    en_p = 1'b0;
    en_q = 1'b0;
    wait_idle(30);
    cfg_write(1'b0, 8'd4, 8'd4);
    en_p = 1'b1;
    wait_rise(0, 5);
    cyc();
    cfg_write(1'b0, 8'd2, 8'd6);
    cfg_sel = 1'b0;
    check("shadow_ready_low", cfg_ready, 1'b0);
    wait_rise(0, 12);
    check("shadow_old_period", spacing[0], 8);
    check("shadow_old_high", last_hi[0], 4);
    check("shadow_ready_back", cfg_ready, 1'b1);
    wait_rise(0, 12);
    check("shadow_new_period", spacing[0], 8);
    check("shadow_new_high", last_hi[0], 2);

    // Graceful stop: drop enable on the second high cycle of a 4/4 period.
    cfg_write(1'b0, 8'd4, 8'd4);
    wait_rise(0, 12);
    cyc();
    en_p = 1'b0;
    ones = 0;
    rises = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (p_clk) ones++;
      if (p_rise) rises++;
    end
    check("stop_high_cycles", ones, 2);
    check("stop_no_rise", rises, 0);
    check("stop_clk_low", p_clk, 1'b0);

    // Edge values: 0/0 gives period 2, 255/255 gives period 510.
    cfg_write(1'b0, 8'd0, 8'd0);
    en_p = 1'b1;
    repeat (9) cyc();
    check("min_period", spacing[0], 2);
    check("min_high", last_hi[0], 1);
    cfg_write(1'b0, 8'd255, 8'd255);
    wait_rise(0, 6);
    wait_rise(0, 600);
    check("max_period", spacing[0], 510);
    check("max_high", last_hi[0], 255);

    // Reset with both channels running and a P update pending.
    en_q = 1'b1;
    repeat (3) cyc();
    cfg_write(1'b0, 8'd3, 8'd3);
    cfg_sel = 1'b0;
    check("pre_reset_pending", cfg_ready, 1'b0);
    rst_n = 1'b0;
    cyc();
    check("rst_p_clk", p_clk, 1'b0);
    check("rst_q_clk", q_clk, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    en_q = 1'b0;
    wait_rise(0, 4);
    wait_rise(0, 12);
    check("restart_period", spacing[0], 8);
    check("restart_high", last_hi[0], 4);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) en_p = ~en_p;
      if ($urandom_range(19) == 0) en_q = ~en_q;
      cfg_valid = ($urandom_range(3) == 0);
      cfg_sel   = 1'($urandom_range(1));
      cfg_high  = 8'($urandom_range(4));
      cfg_low   = 8'($urandom_range(4));
      rst_n     = ($urandom_range(249) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
